sw_array_seq: RTL
=================

# sw_array_seq

Sequencer that runs one Smith-Waterman target sequence through the systolic PE chain. On a start request it reads the target characters from the target buffer and drives the chain head with a framed token stream: SOF (3'b001) on the first character, DATA (3'b100) on the rest, EOF (3'b010) as the terminator. It then waits for the wavefront to leave the last PE and signals completion. It sits between the host/job controller and PE 0's token/character inputs.

## Interface
- PE_NUM, 16, number of PEs in the chain; sets the drain length in cycles
- CHAR_W, 2, character width (DNA = 2 bits)
- LEN_W, 8, width of the target length and buffer address
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- tgt_len  in  LEN_W  target length in characters; sampled with start
- rd_en  out  1  target buffer read enable (registered)
- rd_addr  out  LEN_W  target buffer read address (registered)
- rd_data  in  CHAR_W  buffer data, valid exactly 1 cycle after rd_en
- t_o  out  3  token to PE 0: 000 idle, 001 SOF, 100 DATA, 010 EOF
- char_o  out  CHAR_W  character to PE 0; 0 when t_o is 000 or 010
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse when start arrives with tgt_len == 0
- abort  in  1  abort request; present only with SW_ABORT_EN
- aborted  out  1  high from an abort's done pulse until the next accepted start; present only with SW_ABORT_EN

## Operation
- States: IDLE, FETCH, STREAM, DRAIN.
  - IDLE -> FETCH when start=1 and tgt_len!=0.
  - FETCH lasts while reads are being issued.
  - FETCH -> STREAM when the last read is issued.
  - STREAM -> DRAIN when EOF is emitted.
  - DRAIN -> IDLE after PE_NUM cycles.
- Start with tgt_len == 0: no state change, err=1 for one cycle.
- start while busy=1: ignored, no err.
- Read index counter is LEN_W bits and counts 0..len-1. A length of 2^LEN_W-1 is legal. The counter must not wrap.
- Read data goes into a one-stage output register:
  - t_o = 001 for index 0, 100 for indices 1..len-1.
  - char_o = rd_data.
- Exactly one EOF follows the last character. t_o returns to 000 afterwards.
- Drain counter is $clog2(PE_NUM+1) bits. It loads PE_NUM at EOF and decrements to 0.
- Reset values (any time, including mid-job):
  - t_o=000, char_o=0, rd_en=0, rd_addr=0, busy=0, done=0, err=0, aborted=0.
  - State returns to IDLE.
  - No EOF is emitted on reset.

## Timing
- Cycle 0: start accepted. Cycle 1: busy=1.
- Reads: rd_en=1, rd_addr=k at cycle 1+k for k=0..len-1. rd_en=0 otherwise.
- Tokens:
  - Cycle 3: t_o=001, char_o=mem[0].
  - Cycle 3+k: t_o=100, char_o=mem[k] for k≥1.
  - Cycle 3+len: t_o=010.
- Start-to-SOF latency: 3 cycles. The stream is gap-free; no bubble tokens appear between SOF and EOF.
- done=1 at cycle 3+len+PE_NUM, and busy=1 in that same cycle.
- Cycle 4+len+PE_NUM: busy=0, IDLE. A start in this cycle is accepted, giving back-to-back jobs with no extra gap.

## Configuration
- Macro: SW_ABORT_EN.
- Without it: abort and aborted ports do not exist, and jobs always run to completion.
- With it, abort is sampled while busy=1 and EOF has not yet been emitted:
  - If no SOF has been emitted yet: next cycle rd_en=0, state IDLE, busy=0, done=1, aborted=1. No tokens are emitted.
  - If SOF has been emitted: next cycle t_o=010, and in-flight read data is discarded. Then DRAIN for PE_NUM cycles, then done=1 with aborted=1.
  - If the abort cycle is the one before the natural EOF: EOF timing is unchanged and aborted=1.
- Abort is ignored in IDLE, in DRAIN, and in the cycle EOF is on t_o.

## Test plan
- PE_NUM=16, tgt_len=4, mem={3,1,0,2}, start at cycle 0 -> t_o 001,100,100,100,010 at cycles 3..7; char_o 3,1,0,2,0; done at cycle 23; busy cycles 1..23.
- tgt_len=1 -> single SOF at cycle 3, EOF at cycle 4, done at cycle 20; no DATA token.
- start with tgt_len=0 -> err pulse the next cycle, busy stays 0, t_o stays 000.
- Second start one cycle after done, plus a start pulse mid-job -> the mid-job start is ignored; the second job's SOF comes exactly 3 cycles after its start.
- rst asserted at cycle 5 of a tgt_len=10 job -> all outputs 0 that cycle, no EOF; a later job runs normally.
- SW_ABORT_EN:
  - abort at cycle 2 -> done+aborted at cycle 3, no tokens.
  - abort at cycle 5 with tgt_len=10 -> EOF at cycle 6, done at cycle 22, aborted held until the next start.

Source files
------------

// File: rtl/sw_array_seq.sv
// -----------------------------------------------------------------------------
// sw_array_seq
// Runs one Smith-Waterman target sequence through the systolic PE chain.
// On an accepted start it reads tgt_len characters from the target buffer and
// streams them into PE 0 as a framed, gap-free token stream (SOF on the first
// character, DATA on the rest, then one EOF). It then waits PE_NUM cycles for
// the wavefront to leave the last PE and pulses done.
//
// Optional feature macro: SW_ABORT_EN (adds the abort / aborted ports).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   start    in   job request, sampled only in IDLE
//   tgt_len  in   target length in characters, sampled with start
//   rd_en    out  target buffer read enable (registered)
//   rd_addr  out  target buffer read address (registered)
//   rd_data  in   buffer data, valid one cycle after rd_en
//   t_o      out  token to PE 0: 000 idle, 001 SOF, 100 DATA, 010 EOF
//   char_o   out  character to PE 0 (0 for idle/EOF tokens)
//   busy     out  job in progress (cycle after accept through done cycle)
//   done     out  one-cycle completion pulse
//   err      out  one-cycle pulse for a start with tgt_len == 0
//   abort    in   abort request               (SW_ABORT_EN only)
//   aborted  out  last job ended by an abort  (SW_ABORT_EN only)
// -----------------------------------------------------------------------------
module sw_array_seq #(
    parameter int unsigned PE_NUM = 16,
    parameter int unsigned CHAR_W = 2,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  tgt_len,
    output logic              rd_en,
    output logic [LEN_W-1:0]  rd_addr,
    input  logic [CHAR_W-1:0] rd_data,
    output logic [2:0]        t_o,
    output logic [CHAR_W-1:0] char_o,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SW_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam int unsigned CNT_W = $clog2(PE_NUM + 1);

    localparam logic [2:0] TOK_IDLE = 3'b000;
    localparam logic [2:0] TOK_SOF  = 3'b001;
    localparam logic [2:0] TOK_DATA = 3'b100;
    localparam logic [2:0] TOK_EOF  = 3'b010;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                rd_en_q, rd_en_d;
    logic [LEN_W-1:0]    rd_addr_q, rd_addr_d;
    // Read-return pipeline: marks the cycle rd_data is valid and its position.
    logic                vld_q, vld_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                eof_pend_q, eof_pend_d;
    logic [2:0]          tok_q, tok_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic accept;
    logic last_rd;
    logic kill_early;
    logic kill_late;

    assign accept  = (state_q == IDLE) && start && (tgt_len != '0);
    // Compare against len-1 so a full-range length never needs a wider counter.
    assign last_rd = (rd_addr_q == (len_q - LEN_W'(1)));

`ifdef SW_ABORT_EN
    logic sof_sent_q, sof_sent_d;
    logic abort_pend_q, abort_pend_d;
    logic aborted_q, aborted_d;
    logic abort_live;

    // Abort only matters while busy and before EOF reaches t_o.
    assign abort_live = abort && ((state_q == FETCH) || (state_q == STREAM));
    assign kill_early = abort_live && !sof_sent_q;
    assign kill_late  = abort_live &&  sof_sent_q;
`else
    assign kill_early = 1'b0;
    assign kill_late  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = FETCH;
            FETCH: begin
                if (kill_early)     state_d = IDLE;
                else if (kill_late) state_d = DRAIN;
                else if (last_rd)   state_d = STREAM;
            end
            STREAM: begin
                if (kill_early)                   state_d = IDLE;
                else if (kill_late || eof_pend_q) state_d = DRAIN;
            end
            DRAIN:  if (cnt_q == '0) state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        len_d      = len_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        vld_d      = rd_en_q;
        first_d    = (rd_addr_q == '0);
        last_d     = last_rd;
        eof_pend_d = vld_q && last_q;
        tok_d      = TOK_IDLE;
        char_d     = '0;
        if (vld_q) begin
            tok_d  = first_q ? TOK_SOF : TOK_DATA;
            char_d = rd_data;
        end else if (eof_pend_q) begin
            tok_d  = TOK_EOF;
        end

        cnt_d = cnt_q;
        if ((state_q == DRAIN) && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
        if ((state_q != DRAIN) && (state_d == DRAIN)) cnt_d = CNT_W'(PE_NUM);

        done_d = (state_q == DRAIN) && (cnt_q == CNT_W'(1));
        err_d  = (state_q == IDLE) && start && (tgt_len == '0);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d     = tgt_len;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            FETCH: begin
                if (!last_rd) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + LEN_W'(1);
                end
            end
            default: ;
        endcase

        // Abort flushes the read pipeline; after SOF the stream is closed
        // with an immediate EOF, before SOF nothing is ever emitted.
        if (kill_early || kill_late) begin
            rd_en_d    = 1'b0;
            vld_d      = 1'b0;
            eof_pend_d = 1'b0;
            char_d     = '0;
            tok_d      = kill_late ? TOK_EOF : TOK_IDLE;
        end
        if (kill_early) done_d = 1'b1;
    end

`ifdef SW_ABORT_EN
    always_comb begin
        sof_sent_d   = sof_sent_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        if (accept) begin
            sof_sent_d   = 1'b0;
            abort_pend_d = 1'b0;
            aborted_d    = 1'b0;
        end else begin
            if (tok_d == TOK_SOF) sof_sent_d = 1'b1;
            if (kill_late) abort_pend_d = 1'b1;
            if (done_d && (abort_pend_q || kill_early)) aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_sent_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            sof_sent_q   <= sof_sent_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            eof_pend_q <= 1'b0;
            tok_q      <= TOK_IDLE;
            char_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
            eof_pend_q <= eof_pend_d;
            tok_q      <= tok_d;
            char_q     <= char_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign t_o     = tok_q;
    assign char_o  = char_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule
